flash_controller: RTL

Responder side of the `need_to_work` / `work_done` flash-read handshake. It accepts a 22-bit word address from a requester such as the boot loader, and drives the board's 16-bit parallel NOR flash through a timed read cycle. It then returns the word with a one-cycle done pulse. It sits between the requester and the flash pins, and is the only block that touches the flash bus.

---
 rtl/flash_controller_pkg.sv | 23 ++
 rtl/flash_controller.sv | 130 +++++++++++++
 2 files changed

// File: rtl/flash_controller_pkg.sv
// Shared types and constants for the NOR flash read controller.
package flash_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_SETUP,
        S_CMD_WE,
        S_CMD_HOLD,
        S_READ,
        S_DONE,
        S_RELEASE
    } flash_state_t;

    localparam logic [15:0] FLASH_CMD_READ_ARRAY = 16'h00FF;

    // Width of the shared wait-state counter; it holds at most max(a, b) - 1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/flash_controller.sv
// Responder for the need_to_work / work_done handshake: issues the read-array
// command once per reset, then runs timed OE# reads on a 16-bit parallel NOR flash.
module flash_controller
    import flash_controller_pkg::*;
#(
    parameter int WE_CYCLES     = 4,
    parameter int ACCESS_CYCLES = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flash_need_to_work,
    input  logic [22:1] flash_addr_in,
    output logic        flash_work_done,
    output logic [15:0] flash_data_out,
    output logic [22:1] flash_a,
    inout  wire  [15:0] flash_d,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    output logic        flash_we_n,
    output logic        flash_byte_n,
    output logic        flash_rp_n,
    output logic        flash_vpen
);

    localparam int CW = cnt_width(WE_CYCLES, ACCESS_CYCLES);
    localparam logic [CW-1:0] WE_LOAD     = CW'(WE_CYCLES - 1);
    localparam logic [CW-1:0] ACCESS_LOAD = CW'(ACCESS_CYCLES - 1);

    flash_state_t  state;
    logic [CW-1:0] cnt;
    logic          array_mode;
    logic          drive;

    assign flash_d      = drive ? FLASH_CMD_READ_ARRAY : 16'bz;
    assign flash_byte_n = 1'b1;
    assign flash_rp_n   = 1'b1;
    assign flash_vpen   = 1'b1;

    // NOTE: every strobe is registered and updated on the transition into the
    // state that needs it, so the pins never glitch and OE#/WE#/drive change on
    // the same clean edge; state and outputs use non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            cnt             <= '0;
            array_mode      <= 1'b0;
            drive           <= 1'b0;
            flash_work_done <= 1'b0;
            flash_data_out  <= '0;
            flash_a         <= '0;
            flash_ce_n      <= 1'b1;
            flash_oe_n      <= 1'b1;
            flash_we_n      <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (flash_need_to_work) begin
                        flash_a    <= flash_addr_in;
                        flash_ce_n <= 1'b0;
                        if (array_mode) begin
                            flash_oe_n <= 1'b0;
                            cnt        <= ACCESS_LOAD;
                            state      <= S_READ;
                        end else begin
                            drive <= 1'b1;
                            state <= S_CMD_SETUP;
                        end
                    end
                end

                S_CMD_SETUP: begin
                    flash_we_n <= 1'b0;
                    cnt        <= WE_LOAD;
                    state      <= S_CMD_WE;
                end

                S_CMD_WE: begin
                    if (cnt == '0) begin
                        flash_we_n <= 1'b1;
                        state      <= S_CMD_HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                // Bus is released on the same edge OE# falls, so the flash and
                // this block never drive flash_d together.
                S_CMD_HOLD: begin
                    drive      <= 1'b0;
                    array_mode <= 1'b1;
                    flash_oe_n <= 1'b0;
                    cnt        <= ACCESS_LOAD;
                    state      <= S_READ;
                end

                S_READ: begin
                    if (cnt == '0) begin
                        flash_data_out  <= flash_d;
                        flash_work_done <= 1'b1;
                        flash_ce_n      <= 1'b1;
                        flash_oe_n      <= 1'b1;
                        state           <= S_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                S_DONE: begin
                    flash_work_done <= 1'b0;
                    state           <= S_RELEASE;
                end

                // Wait for the request level to drop so one request yields one done.
                S_RELEASE: begin
                    if (!flash_need_to_work) state <= S_IDLE;
                end

                default: begin
                    drive           <= 1'b0;
                    flash_work_done <= 1'b0;
                    flash_ce_n      <= 1'b1;
                    flash_oe_n      <= 1'b1;
                    flash_we_n      <= 1'b1;
                    state           <= S_IDLE;
                end
            endcase
        end
    end

endmodule
